// File: rtl/w_scheduler_if.sv
// SHA-256 message-schedule handshake bundle: word load in, Wt/round out.
// blk_cnt exists only when SCHED_BLOCK_CNT_EN is defined.
interface w_scheduler_if;
  logic [31:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_w;
  logic [5:0]  out_round;
  logic        out_valid;
  logic        out_ready;
  logic        done;
`ifdef SCHED_BLOCK_CNT_EN
  logic [15:0] blk_cnt;
`endif

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_w, out_round, out_valid, done
`ifdef SCHED_BLOCK_CNT_EN
    , input blk_cnt
`endif
  );

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_w, out_round, out_valid, done
`ifdef SCHED_BLOCK_CNT_EN
    , output blk_cnt
`endif
  );
endinterface

// File: rtl/w_scheduler.sv
// SHA-256 message schedule: loads 16 words, emits W0..W(ROUNDS-1).
// Optional block counter output enabled by SCHED_BLOCK_CNT_EN.
module w_scheduler #(
  parameter int ROUNDS = 64
) (
  input logic           clk,
  input logic           rst,
  w_scheduler_if.slave  bus
);

  typedef enum logic {S_LOAD, S_EMIT} state_e;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [3:0]  lcnt_q, lcnt_d;
  logic [5:0]  rcnt_q, rcnt_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        done_q, done_d;
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] w_next;
  logic        in_xfer, out_xfer;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = out_valid_q & bus.out_ready;
  // window holds W[t..t+15]; this is W[t+16]
  assign w_next   = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

  always_comb begin
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    rcnt_d      = rcnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    w_d         = w_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_xfer) begin
          w_d[lcnt_q] = bus.in_word;
          lcnt_d      = lcnt_q + 4'd1;
          if (lcnt_q == 4'd15) begin
            state_d     = S_EMIT;
            rcnt_d      = '0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (out_xfer) begin
          for (int k = 0; k < 15; k++) begin
            w_d[k] = w_q[k+1];
          end
          w_d[15] = w_next;
          rcnt_d  = rcnt_q + 6'd1;
          if (rcnt_q == LAST) begin
            state_d     = S_LOAD;
            rcnt_d      = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      lcnt_q      <= '0;
      rcnt_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      rcnt_q      <= rcnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // window is don't-care after reset, so it carries no reset
  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_w     = w_q[0];
  assign bus.out_round = rcnt_q;
  assign bus.done      = done_q;

`ifdef SCHED_BLOCK_CNT_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (done_d) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign bus.blk_cnt = blk_cnt_q;
`endif

endmodule
